ddr_bank_timing_model: RTL
==========================

# ddr_bank_timing_model

Cycle-level, parametrised DRAM bank model for controller-side simulation. It sits behind the command/data interface of a memory controller under test and tracks every bank's open/closed state. It enforces tRCD/tRAS/tRP/tRFC, returns read data after a fixed CAS latency, and flags protocol violations. It trades board-level pin accuracy for fast, checkable command-level behaviour with any bank count and data width.

## Interface
- NUM_BANKS, 8, number of banks (power of two)
- BANK_WIDTH, 3, log2(NUM_BANKS)
- ROW_WIDTH, 14, row address bits
- COL_WIDTH, 10, column address bits (COL_WIDTH ≤ ROW_WIDTH)
- DATA_WIDTH, 64, data word width (multiple of 8)
- MEM_AW, 10, backing-store address bits (2^MEM_AW words)
- T_RCD, 5, ACT→RD/WR cycles (≥1)
- T_RAS, 14, ACT→PRE cycles (≥1)
- T_RP, 5, PRE→ACT cycles (≥1)
- T_CL, 5, RD accept→rd_valid cycles (≥1)
- T_RFC, 20, REF busy cycles (≥1)

Ports:
- sys_clk  in  1  single clock, all logic rising-edge
- sys_rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  model accepts command this cycle
- cmd_op  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6–7 illegal
- cmd_ba  in  BANK_WIDTH  target bank
- cmd_addr  in  ROW_WIDTH  row (ACT) or column in low COL_WIDTH bits (RD/WR)
- wr_data  in  DATA_WIDTH  write data, valid with WR
- wr_mask  in  DATA_WIDTH/8  byte mask, 1 = byte NOT written
- rd_valid  out  1  read data valid
- rd_data  out  DATA_WIDTH  read data
- err_valid  out  1  one-cycle violation pulse
- err_code  out  3  violation code
- err_bank  out  BANK_WIDTH  bank of violation
- err_count  out  16  saturating violation count
- bank_open  out  NUM_BANKS  bit b = bank b ACTIVE

## Operation
- Accept = cmd_valid & cmd_ready. Commands not accepted have no effect.
- Per-bank FSM: IDLE, ACTIVATING, ACTIVE, PRECHARGING; per-bank open_row register, tRCD/tRAS/tRP down-counters.
- ACT on IDLE: → ACTIVATING, latch open_row. ACT on any other state: error 1.
- RD/WR on ACTIVE: legal. On any other state: error 2.
- PRE on ACTIVE with tRAS expired: → PRECHARGING. PRE before tRAS expiry (ACTIVATING, or ACTIVE with counter nonzero): error 3. PRE on IDLE or PRECHARGING: no-op, no error.
- REF with all banks IDLE: cmd_ready low for T_RFC cycles. REF otherwise: error 4.
- cmd_op 6/7: error 5. NOP: nothing.
- Illegal command: no state, storage or read-pipe change.
- Store index = low MEM_AW bits of {cmd_ba, open_row[cmd_ba], cmd_addr[COL_WIDTH-1:0]}.
- WR writes unmasked bytes at the accept edge.
- RD samples the store at the accept edge and enters a T_CL-deep shift pipe. One RD per cycle is sustained.
- err_count increments per error and saturates at 16'hFFFF.
- Storage contents are not reset.

## Timing
- Reset values: cmd_ready=1, rd_valid=0, rd_data=0, err_valid=0, err_code=0, err_bank=0, err_count=0, bank_open=0. All banks IDLE, counters 0, REF busy cleared.
- Reset mid-operation flushes the read pipe; in-flight reads are never returned.
- ACT accepted at cycle t: RD/WR legal from t+T_RCD; bank_open[b]=1 from t+T_RCD; PRE legal from t+T_RAS.
- PRE accepted at t: bank_open[b]=0 at t+1; ACT legal from t+T_RP.
- RD accepted at t: rd_valid=1, rd_data valid at cycle t+T_CL for exactly one cycle. Back-to-back RDs produce back-to-back rd_valid.
- WR at t followed by RD at t+1 to the same index returns the new data.
- REF accepted at t: cmd_ready=0 for cycles t+1 … t+T_RFC, then 1 at t+T_RFC+1.
- Error on command at t: err_valid=1 with code/bank at t+1; err_count updated at t+1.
- Different banks are fully independent; commands may interleave every cycle.

## Test plan
- Default params: ACT b2 row 0x12 @t0, WR b2 col 0x3 data 0xA5A5…, mask 0 @t5, RD same @t6 → rd_valid only at t11, rd_data 0xA5A5…, err_count 0.
- ACT b0 @t0, RD b0 @t3 → err_valid @t4, code 2, bank 0, no rd_valid. RD @t5 → rd_valid @t10.
- ACT b1 @t0, PRE b1 @t10 → code 3. PRE @t14 → bank_open[1]=0 @t15. ACT b1 @t16 → code 1. ACT b1 @t19 → accepted.
- REF with b4 open → code 4. After PRE and tRP, REF @t → cmd_ready low t+1…t+20. ACT presented during busy is ignored.
- WR 0xFFFF… then WR 0x0 with mask 8'h0F, then RD → 0x00000000FFFFFFFF (low four bytes preserved, high four overwritten). Eight back-to-back RDs → eight consecutive rd_valid.
- Assert sys_rst two cycles after a RD → no rd_valid ever, all outputs at reset values; 70000 illegal op-7 commands → err_count saturates at 0xFFFF.

Source files
------------

// File: rtl/ddr_bank_timing_model.sv
// rtl/ddr_bank_timing_model.sv - cycle-level DRAM bank state, timing and data model
module ddr_bank_timing_model #(
  parameter int NUM_BANKS  = 8,
  parameter int BANK_WIDTH = 3,
  parameter int ROW_WIDTH  = 14,
  parameter int COL_WIDTH  = 10,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_AW     = 10,
  parameter int T_RCD      = 5,
  parameter int T_RAS      = 14,
  parameter int T_RP       = 5,
  parameter int T_CL       = 5,
  parameter int T_RFC      = 20
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [BANK_WIDTH-1:0]   cmd_ba,
  input  logic [ROW_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_mask,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    err_valid,
  output logic [2:0]              err_code,
  output logic [BANK_WIDTH-1:0]   err_bank,
  output logic [15:0]             err_count,
  output logic [NUM_BANKS-1:0]    bank_open
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int TMAX   = (T_RCD > T_RP) ? ((T_RCD > T_RAS) ? T_RCD : T_RAS)
                                         : ((T_RP > T_RAS) ? T_RP : T_RAS);
  localparam int TW     = $clog2(TMAX + 1);
  localparam int FW     = $clog2(T_RFC + 1);
  localparam int IW     = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [TW-1:0] RCD_LOAD = TW'(T_RCD - 1);
  localparam logic [TW-1:0] RAS_LOAD = TW'(T_RAS - 1);
  localparam logic [TW-1:0] RP_LOAD  = TW'(T_RP - 1);
  localparam logic [FW-1:0] RFC_LOAD = FW'(T_RFC);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ACT = 3'd1;
  localparam logic [2:0] OP_RD  = 3'd2;
  localparam logic [2:0] OP_WR  = 3'd3;
  localparam logic [2:0] OP_PRE = 3'd4;
  localparam logic [2:0] OP_REF = 3'd5;

  localparam logic [2:0] ERR_ACT = 3'd1;
  localparam logic [2:0] ERR_RW  = 3'd2;
  localparam logic [2:0] ERR_PRE = 3'd3;
  localparam logic [2:0] ERR_REF = 3'd4;
  localparam logic [2:0] ERR_OP  = 3'd5;

  typedef enum logic [1:0] {IDLE, ACTIVATING, ACTIVE, PRECHARGING} bank_state_e;

  bank_state_e           state_q    [NUM_BANKS];
  bank_state_e           state_d    [NUM_BANKS];
  logic [TW-1:0]         tmr_q      [NUM_BANKS];
  logic [TW-1:0]         tmr_d      [NUM_BANKS];
  logic [TW-1:0]         ras_q      [NUM_BANKS];
  logic [TW-1:0]         ras_d      [NUM_BANKS];
  logic [ROW_WIDTH-1:0]  open_row_q [NUM_BANKS];
  logic [ROW_WIDTH-1:0]  open_row_d [NUM_BANKS];

  logic [FW-1:0]         rfc_q, rfc_d;
  logic                  err_valid_q, err_valid_d;
  logic [2:0]            err_code_q, err_code_d;
  logic [BANK_WIDTH-1:0] err_bank_q, err_bank_d;
  logic [15:0]           err_count_q, err_count_d;
  logic [T_CL-1:0]       pipe_vld_q, pipe_vld_d;
  logic [DATA_WIDTH-1:0] pipe_dat_q [T_CL];
  logic [DATA_WIDTH-1:0] pipe_dat_d [T_CL];

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  logic                  accept;
  logic                  all_idle;
  logic                  do_act, do_pre, do_rd, do_wr, do_ref;
  logic                  cmd_err;
  logic [2:0]            cmd_code;
  logic [IW-1:0]         full_idx;
  logic [MEM_AW-1:0]     mem_idx;

  // Decode the accepted command into one legal action or one violation code
  always_comb begin
    accept   = cmd_valid & cmd_ready & ~sys_rst;
    all_idle = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (state_q[b] != IDLE) all_idle = 1'b0;
    end
    full_idx = {cmd_ba, open_row_q[cmd_ba], cmd_addr[COL_WIDTH-1:0]};
    mem_idx  = MEM_AW'(full_idx);
    do_act   = 1'b0;
    do_pre   = 1'b0;
    do_rd    = 1'b0;
    do_wr    = 1'b0;
    do_ref   = 1'b0;
    cmd_err  = 1'b0;
    cmd_code = 3'd0;
    if (accept) begin
      case (cmd_op)
        OP_NOP: ;
        OP_ACT: begin
          if (state_q[cmd_ba] == IDLE) do_act = 1'b1;
          else begin cmd_err = 1'b1; cmd_code = ERR_ACT; end
        end
        OP_RD, OP_WR: begin
          if (state_q[cmd_ba] == ACTIVE) begin
            do_rd = (cmd_op == OP_RD);
            do_wr = (cmd_op == OP_WR);
          end else begin
            cmd_err = 1'b1; cmd_code = ERR_RW;
          end
        end
        OP_PRE: begin
          // PRE to a bank that is already closed or closing is a harmless no-op
          if (state_q[cmd_ba] == ACTIVE && ras_q[cmd_ba] == '0) do_pre = 1'b1;
          else if (state_q[cmd_ba] == ACTIVATING || state_q[cmd_ba] == ACTIVE) begin
            cmd_err = 1'b1; cmd_code = ERR_PRE;
          end
        end
        OP_REF: begin
          if (all_idle) do_ref = 1'b1;
          else begin cmd_err = 1'b1; cmd_code = ERR_REF; end
        end
        default: begin cmd_err = 1'b1; cmd_code = ERR_OP; end
      endcase
    end
  end

  // Per-bank next state: timers run down, the last timer cycle moves the bank on
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      state_d[b]    = state_q[b];
      tmr_d[b]      = tmr_q[b];
      open_row_d[b] = open_row_q[b];
      ras_d[b]      = (ras_q[b] != '0) ? ras_q[b] - T_ONE : ras_q[b];
      case (state_q[b])
        ACTIVATING: begin
          tmr_d[b] = tmr_q[b] - T_ONE;
          if (tmr_q[b] == T_ONE) state_d[b] = ACTIVE;
        end
        PRECHARGING: begin
          tmr_d[b] = tmr_q[b] - T_ONE;
          if (tmr_q[b] == T_ONE) state_d[b] = IDLE;
        end
        default: ;
      endcase
      if (do_act && cmd_ba == BANK_WIDTH'(b)) begin
        open_row_d[b] = cmd_addr;
        tmr_d[b]      = RCD_LOAD;
        ras_d[b]      = RAS_LOAD;
        state_d[b]    = (T_RCD == 1) ? ACTIVE : ACTIVATING;
      end
      if (do_pre && cmd_ba == BANK_WIDTH'(b)) begin
        tmr_d[b]   = RP_LOAD;
        state_d[b] = (T_RP == 1) ? IDLE : PRECHARGING;
      end
    end
  end

  // Refresh busy timer, error reporting and the CAS-latency read pipe
  always_comb begin
    rfc_d       = do_ref ? RFC_LOAD : ((rfc_q != '0) ? rfc_q - FW'(1) : rfc_q);
    err_valid_d = cmd_err;
    err_code_d  = cmd_err ? cmd_code : err_code_q;
    err_bank_d  = cmd_err ? cmd_ba : err_bank_q;
    err_count_d = (cmd_err && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
    pipe_vld_d[0] = do_rd;
    pipe_dat_d[0] = do_rd ? mem[mem_idx] : '0;
    for (int i = 1; i < T_CL; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
  end

  // Bank state registers
  always_ff @(posedge sys_clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (sys_rst) begin
        state_q[b]    <= IDLE;
        tmr_q[b]      <= '0;
        ras_q[b]      <= '0;
        open_row_q[b] <= '0;
      end else begin
        state_q[b]    <= state_d[b];
        tmr_q[b]      <= tmr_d[b];
        ras_q[b]      <= ras_d[b];
        open_row_q[b] <= open_row_d[b];
      end
    end
  end

  // Refresh, error and read-pipe registers; reset drops any in-flight read
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rfc_q       <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      err_bank_q  <= '0;
      err_count_q <= '0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < T_CL; i++) pipe_dat_q[i] <= '0;
    end else begin
      rfc_q       <= rfc_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_bank_q  <= err_bank_d;
      err_count_q <= err_count_d;
      pipe_vld_q  <= pipe_vld_d;
      for (int i = 0; i < T_CL; i++) pipe_dat_q[i] <= pipe_dat_d[i];
    end
  end

  // Backing store: byte-masked write, contents survive reset
  always_ff @(posedge sys_clk) begin
    if (do_wr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (!wr_mask[i]) mem[mem_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // Outputs derived from registered state
  always_comb begin
    cmd_ready = (rfc_q == '0);
    for (int b = 0; b < NUM_BANKS; b++) bank_open[b] = (state_q[b] == ACTIVE);
    rd_valid  = pipe_vld_q[T_CL-1];
    rd_data   = pipe_dat_q[T_CL-1];
    err_valid = err_valid_q;
    err_code  = err_code_q;
    err_bank  = err_bank_q;
    err_count = err_count_q;
  end

endmodule
